rr_mux_arb: RTL and testbench

Parametrised N-channel, DATA_W-bit multiplexer with a registered valid/ready output stage and two selection modes: direct select and round-robin arbitration. It generalises the team's fixed 8-to-1 4-bit combinational mux into a flow-controlled stage. It sits between several producer channels and a single downstream consumer.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_pick.sv | 34 +++
 rtl/rr_mux_arb.sv | 112 +++++++++++
 tb/tb_rr_mux_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and defaults for the flow-controlled channel multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    localparam int DEF_N_CH   = 8;
    localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-find-first picker: the first requesting channel at or above ptr,
// wrapping at N_CH-1 back to 0.
module rr_pick
    import mux_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            gnt_valid,
    output logic [CH_W-1:0] gnt_idx
);

    int idx;

    // Walk offsets from the far end so the smallest offset from ptr wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int off = N_CH - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel multiplexer with direct-select or round-robin grant feeding a
// single registered valid/ready output stage.
module rr_mux_arb
    import mux_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int DATA_W = DEF_DATA_W,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [CH_W-1:0]          sel,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    // Handshake: a word moves on a channel in any cycle where that channel's
    // valid and ready are both high at the rising edge; a producer keeps data
    // stable while valid is high and ready is low. The output side follows the
    // same rule with out_valid/out_ready.

    mode_e               mode_w;
    logic                rr_valid;
    logic [CH_W-1:0]     rr_idx;
    logic                sel_valid;
    logic                grant_valid;
    logic [CH_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_data;
    logic                load_en;
    logic                xfer;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [CH_W-1:0]     out_ch_q,    out_ch_d;
    logic [CH_W-1:0]     ptr_q,       ptr_d;

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Comparing sel against every real index means an out-of-range sel never grants.
    always_comb begin
        sel_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (in_valid[i] && (sel == CH_W'(i))) begin
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        mode_w      = mode_e'(mode);
        grant_valid = (mode_w == MODE_RR) ? rr_valid : sel_valid;
        grant_idx   = (mode_w == MODE_RR) ? rr_idx   : sel;
        load_en     = !out_valid_q || out_ready;
        xfer        = load_en && grant_valid;
    end

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                in_ready[i] = rst_n && xfer;
                grant_data  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            ptr_d       = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: an 8-channel instance driven from a vector
// table plus multi-cycle sequences, and a 5-channel instance for wrap-around.
module tb_rr_mux_arb;

    logic        clk;
    logic        rst_n;

    logic        mode8;
    logic [2:0]  sel8;
    logic [7:0]  iv8;
    logic [31:0] data8;
    logic [7:0]  ir8;
    logic        ov8;
    logic [3:0]  od8;
    logic [2:0]  och8;
    logic        ordy8;

    logic        mode5;
    logic [2:0]  sel5;
    logic [4:0]  iv5;
    logic [19:0] data5;
    logic [4:0]  ir5;
    logic        ov5;
    logic [3:0]  od5;
    logic [2:0]  och5;
    logic        ordy5;

    int checks;
    int errors;
    logic [3:0] exp_q[$];
    logic [3:0] exp_ch;

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [7:0] iv;
        logic       ordy;
        logic [7:0] exp_ir;
        logic       exp_ov;
        logic [3:0] exp_od;
        logic [2:0] exp_och;
    } vec_t;

    vec_t vecs[12];

    rr_mux_arb #(.N_CH(8), .DATA_W(4)) u8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .sel(sel8),
        .in_valid(iv8), .in_data(data8), .in_ready(ir8),
        .out_valid(ov8), .out_data(od8), .out_ch(och8), .out_ready(ordy8)
    );

    rr_mux_arb #(.N_CH(5), .DATA_W(4)) u5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .in_valid(iv5), .in_data(data5), .in_ready(ir5),
        .out_valid(ov5), .out_data(od5), .out_ch(och5), .out_ready(ordy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Channel i carries (i + offs) in the low nibble.
    function automatic logic [31:0] pat8(input int offs);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*4 +: 4] = 4'(i + offs);
        return v;
    endfunction

    function automatic logic [19:0] pat5(input int offs);
        logic [19:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) v[i*4 +: 4] = 4'(i + offs);
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        // Sequential table: each row starts from the state the previous row left.
        //                mode  sel   iv     ordy  exp_ir ov    od    och
        vecs[0]  = '{1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 4'hA, 3'd5};
        vecs[1]  = '{1'b0, 3'd3, 8'h20, 1'b1, 8'h00, 1'b0, 4'hA, 3'd5};
        vecs[2]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h40, 1'b1, 4'hB, 3'd6};
        vecs[3]  = '{1'b1, 3'd0, 8'h03, 1'b0, 8'h00, 1'b1, 4'hB, 3'd6};
        vecs[4]  = '{1'b1, 3'd0, 8'h03, 1'b1, 8'h01, 1'b1, 4'h5, 3'd0};
        vecs[5]  = '{1'b0, 3'd7, 8'h80, 1'b1, 8'h80, 1'b1, 4'hC, 3'd7};
        vecs[6]  = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 4'hC, 3'd7};
        vecs[7]  = '{1'b1, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 4'hC, 3'd7};
        vecs[8]  = '{1'b1, 3'd0, 8'h84, 1'b0, 8'h04, 1'b1, 4'h7, 3'd2};
        vecs[9]  = '{1'b1, 3'd0, 8'h84, 1'b0, 8'h00, 1'b1, 4'h7, 3'd2};
        vecs[10] = '{1'b1, 3'd0, 8'h84, 1'b1, 8'h80, 1'b1, 4'hC, 3'd7};
        vecs[11] = '{1'b1, 3'd0, 8'h84, 1'b1, 8'h04, 1'b1, 4'h7, 3'd2};

        rst_n = 1'b0;
        mode8 = 1'b0; sel8 = 3'd0; iv8 = 8'hFF; ordy8 = 1'b1; data8 = pat8(5);
        mode5 = 1'b0; sel5 = 3'd0; iv5 = 5'b0;  ordy5 = 1'b1; data5 = pat5(1);

        #2;
        chk("reset out_valid", 32'(ov8), 32'd0);
        chk("reset out_data",  32'(od8), 32'd0);
        chk("reset out_ch",    32'(och8), 32'd0);
        chk("reset in_ready",  32'(ir8), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        iv8   = 8'h00;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mode8 = vecs[i].mode; sel8 = vecs[i].sel; iv8 = vecs[i].iv; ordy8 = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d in_ready", i), 32'(ir8), 32'(vecs[i].exp_ir));
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", i), 32'(ov8), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d out_data", i), 32'(od8), 32'(vecs[i].exp_od));
            chk($sformatf("vec%0d out_ch", i), 32'(och8), 32'(vecs[i].exp_och));
        end

        // Reset while a word is held under backpressure.
        @(negedge clk);
        ordy8 = 1'b0; mode8 = 1'b1; iv8 = 8'hFF;
        #1;
        chk("pre-reset out_valid", 32'(ov8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(ov8), 32'd0);
        chk("async reset out_data",  32'(od8), 32'd0);
        chk("async reset out_ch",    32'(och8), 32'd0);
        chk("async reset in_ready",  32'(ir8), 32'd0);

        // Round-robin fairness from a fresh ptr, channel i data = i.
        @(negedge clk);
        rst_n = 1'b1; data8 = pat8(0); ordy8 = 1'b1;
        for (int k = 0; k < 9; k++) exp_q.push_back(4'(k % 8));
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            exp_ch = exp_q.pop_front();
            chk($sformatf("rr%0d out_valid", k), 32'(ov8), 32'd1);
            chk($sformatf("rr%0d out_ch", k), 32'(och8), 32'(exp_ch));
            chk($sformatf("rr%0d out_data", k), 32'(od8), 32'(exp_ch));
        end

        // Backpressure: three stalled cycles, then reload with no bubble.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ordy8 = 1'b0;
            #1;
            chk($sformatf("stall%0d in_ready", k), 32'(ir8), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d out_valid", k), 32'(ov8), 32'd1);
            chk($sformatf("stall%0d out_data", k), 32'(od8), 32'd0);
            chk($sformatf("stall%0d out_ch", k), 32'(och8), 32'd0);
        end
        @(negedge clk);
        ordy8 = 1'b1;
        #1;
        chk("unstall in_ready", 32'(ir8), 32'h02);
        @(posedge clk); #1;
        chk("unstall out_ch", 32'(och8), 32'd1);
        chk("unstall out_valid", 32'(ov8), 32'd1);

        // Mode switch with ptr=3: select channel 6, then RR resumes at 7.
        @(negedge clk);
        @(posedge clk); #1;
        chk("pre-switch out_ch", 32'(och8), 32'd2);
        @(negedge clk);
        mode8 = 1'b0; sel8 = 3'd6;
        #1;
        chk("switch sel in_ready", 32'(ir8), 32'h40);
        @(posedge clk); #1;
        chk("switch sel out_ch", 32'(och8), 32'd6);
        chk("switch sel out_data", 32'(od8), 32'd6);
        @(negedge clk);
        mode8 = 1'b1;
        #1;
        chk("switch rr in_ready", 32'(ir8), 32'h80);
        @(posedge clk); #1;
        chk("switch rr out_ch", 32'(och8), 32'd7);

        // Five channels, sparse requests: grants wrap at channel 4.
        @(negedge clk);
        mode5 = 1'b1; iv5 = 5'b10010; ordy5 = 1'b1;
        exp_q.push_back(4'd1); exp_q.push_back(4'd4);
        exp_q.push_back(4'd1); exp_q.push_back(4'd4);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            exp_ch = exp_q.pop_front();
            chk($sformatf("n5 rr%0d out_ch", k), 32'(och5), 32'(exp_ch));
            chk($sformatf("n5 rr%0d out_data", k), 32'(od5), 32'(exp_ch + 4'd1));
        end
        @(negedge clk);
        mode5 = 1'b0; sel5 = 3'd6; iv5 = 5'b11111;
        #1;
        chk("n5 sel out-of-range in_ready", 32'(ir5), 32'd0);
        @(posedge clk); #1;
        chk("n5 sel out-of-range out_valid", 32'(ov5), 32'd0);
        @(negedge clk);
        sel5 = 3'd4; iv5 = 5'b10010;
        #1;
        chk("n5 sel4 in_ready", 32'(ir5), 32'h10);
        @(posedge clk); #1;
        chk("n5 sel4 out_ch", 32'(och5), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
